xadac_hazard_sb: RTL and testbench
==================================

Name: xadac_hazard_sb

Overview:
- Parametrised successor to the single-bit clobber tracker. It sits between the core-side and coprocessor-side xadac decode/execute channels.
- It gates only the valid/ready handshakes. The parent routes payloads around the block, except for the id and register fields listed below.
- It tracks each in-flight id through four phases: dec req, dec rsp, exe req, exe rsp. It keeps per-register pending-write counters.
- New relative to the single-bit tracker: multiple outstanding writers per register (WAW), a configurable source count, flush, and a busy indication.

Parameters:
- NumIds, 4, scoreboard entries; ids are 0..NumIds-1.
- NumRegs, 32, vector registers tracked.
- NumSrc, 3, source operands per instruction.
- WrCntW, 2, pending-write counter width; maximum outstanding writers per register = 2^WrCntW-1.
- IdW, $clog2(NumIds), derived.
- RegW, $clog2(NumRegs), derived.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  drop all tracked state
- s_dec_req_valid  in  1;  s_dec_req_ready  out  1
- s_dec_req_id  in  IdW;  s_dec_req_vd  in  RegW
- m_dec_req_valid  out  1;  m_dec_req_ready  in  1
- m_dec_rsp_valid  in  1;  m_dec_rsp_ready  out  1
- m_dec_rsp_id  in  IdW;  m_dec_rsp_accept  in  1
- m_dec_rsp_vd_wr  in  1;  m_dec_rsp_vs_rd  in  NumSrc
- s_dec_rsp_valid  out  1;  s_dec_rsp_ready  in  1
- s_exe_req_valid  in  1;  s_exe_req_ready  out  1
- s_exe_req_id  in  IdW;  s_exe_req_vs  in  NumSrc*RegW  (source i at bits [i*RegW +: RegW])
- m_exe_req_valid  out  1;  m_exe_req_ready  in  1
- m_exe_rsp_valid  in  1;  m_exe_rsp_ready  out  1;  m_exe_rsp_id  in  IdW
- s_exe_rsp_valid  out  1;  s_exe_rsp_ready  in  1
- busy_o  out  1  any entry or counter non-zero

Behaviour:
- Reset and flush:
  - Reset (rst=1 at a clk edge) clears all entries and counters. All valid/ready outputs are 0 while rst=1. busy_o=0 after reset.
  - flush_i takes priority over every handshake in the same cycle: all outputs other than busy_o are forced to 0, and entries and counters are cleared at the edge.
- Entry fields: vd, vd_wr, vs_rd[NumSrc], and the done flags dreq, drsp, ereq, ersp.
- All gating uses registered state only. A phase completed in cycle N can enable the next phase at the earliest in cycle N+1.
- Dec req:
  - m_dec_req_valid = s_dec_req_valid & !dreq[id].
  - s_dec_req_ready = m_dec_req_valid & m_dec_req_ready.
  - On fire: latch vd, set dreq.
- Dec rsp:
  - s_dec_rsp_valid = m_dec_rsp_valid & dreq & !drsp.
  - m_dec_rsp_ready = s_dec_rsp_valid & s_dec_rsp_ready.
  - On fire with accept=1: latch vd_wr and vs_rd, set drsp.
  - On fire with accept=0: entry cleared at the edge.
- Exe req:
  - m_exe_req_valid = s_exe_req_valid & drsp & !ereq & no hazard.
  - Hazard: any i with vs_rd[i] and cnt[vs_i] != 0 (RAW), or vd_wr and cnt[vd] == max (saturation).
  - Writers to a register with 0 < cnt < max are allowed (WAW, in-order completion downstream).
  - On fire: set ereq; if vd_wr, cnt[vd] += 1.
- Exe rsp:
  - s_exe_rsp_valid = m_exe_rsp_valid & ereq & !ersp.
  - m_exe_rsp_ready = s_exe_rsp_valid & s_exe_rsp_ready.
  - On fire: if vd_wr, cnt[vd] -= 1; the entry is then cleared (retired).
- Same-register increment and decrement in one cycle: net 0. The counter never wraps; underflow is impossible by construction.
- Different ids may complete different phases in the same cycle. Same-id phases in one cycle cannot occur, because the done flags are registered.
- A response for an id not in the matching phase is never made ready; it stalls until the phase is legal, flush or reset.

Optional Feature:
- Macro XADAC_HAZARD_SB_STATS_EN.
- When defined: adds output stall_cnt_o (32 bits). It increments once per cycle in which s_exe_req_valid=1 and drsp=1 but a hazard blocks issue. It saturates at all-ones and is cleared by rst or flush_i.
- When undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Full flow for id 0 with vd=5 and vd_wr=1: after exe req fires, cnt[5]=1 and busy_o=1. After exe rsp fires, cnt[5]=0, busy_o=0 and the entry is free.
- RAW: id 0 writing v5 has issued and is pending. Id 1 reads v5 (vs_rd[0]=1, vs=5) with s_exe_req_valid=1 → m_exe_req_valid=0 until the cycle after id 0's exe rsp fires, then 1.
- WAW saturation (WrCntW=2): three writers to v3 issue back-to-back. The fourth is held with m_exe_req_valid=0 until one rsp fires.
- Reject: dec rsp for id 2 with accept=0 → entry cleared. The next cycle, s_dec_req_valid for id 2 is forwarded again (m_dec_req_valid=1).
- Flush with 3 entries in flight and cnt[7]=2 → the next cycle busy_o=0, and a read of v7 issues immediately.
- Simultaneous events: in one cycle, exe req for id 1 writes v4 while exe rsp for id 0 retires a write to v4 with cnt[4]=1 → cnt[4] stays 1.

Source files
------------

// File: rtl/xadac_hazard_sb_if.sv
// Handshake and id/register fields between the core-side (s_*) and coprocessor-side (m_*)
// xadac decode/execute channels, as seen by the hazard scoreboard.
interface xadac_hazard_sb_if #(
    parameter int IdW    = 2,
    parameter int RegW   = 5,
    parameter int NumSrc = 3
);
    logic                   s_dec_req_valid;
    logic                   s_dec_req_ready;
    logic [IdW-1:0]         s_dec_req_id;
    logic [RegW-1:0]        s_dec_req_vd;
    logic                   m_dec_req_valid;
    logic                   m_dec_req_ready;
    logic                   m_dec_rsp_valid;
    logic                   m_dec_rsp_ready;
    logic [IdW-1:0]         m_dec_rsp_id;
    logic                   m_dec_rsp_accept;
    logic                   m_dec_rsp_vd_wr;
    logic [NumSrc-1:0]      m_dec_rsp_vs_rd;
    logic                   s_dec_rsp_valid;
    logic                   s_dec_rsp_ready;
    logic                   s_exe_req_valid;
    logic                   s_exe_req_ready;
    logic [IdW-1:0]         s_exe_req_id;
    logic [NumSrc*RegW-1:0] s_exe_req_vs;
    logic                   m_exe_req_valid;
    logic                   m_exe_req_ready;
    logic                   m_exe_rsp_valid;
    logic                   m_exe_rsp_ready;
    logic [IdW-1:0]         m_exe_rsp_id;
    logic                   s_exe_rsp_valid;
    logic                   s_exe_rsp_ready;

    modport slave (
        input  s_dec_req_valid, s_dec_req_id, s_dec_req_vd, m_dec_req_ready,
        input  m_dec_rsp_valid, m_dec_rsp_id, m_dec_rsp_accept, m_dec_rsp_vd_wr, m_dec_rsp_vs_rd,
        input  s_dec_rsp_ready, s_exe_req_valid, s_exe_req_id, s_exe_req_vs, m_exe_req_ready,
        input  m_exe_rsp_valid, m_exe_rsp_id, s_exe_rsp_ready,
        output s_dec_req_ready, m_dec_req_valid, m_dec_rsp_ready, s_dec_rsp_valid,
        output s_exe_req_ready, m_exe_req_valid, m_exe_rsp_ready, s_exe_rsp_valid
    );

    modport master (
        output s_dec_req_valid, s_dec_req_id, s_dec_req_vd, m_dec_req_ready,
        output m_dec_rsp_valid, m_dec_rsp_id, m_dec_rsp_accept, m_dec_rsp_vd_wr, m_dec_rsp_vs_rd,
        output s_dec_rsp_ready, s_exe_req_valid, s_exe_req_id, s_exe_req_vs, m_exe_req_ready,
        output m_exe_rsp_valid, m_exe_rsp_id, s_exe_rsp_ready,
        input  s_dec_req_ready, m_dec_req_valid, m_dec_rsp_ready, s_dec_rsp_valid,
        input  s_exe_req_ready, m_exe_req_valid, m_exe_rsp_ready, s_exe_rsp_valid
    );
endinterface

// File: rtl/xadac_hazard_sb.sv
// Per-id phase tracker and per-register pending-write counters gating xadac handshakes.
// Optional macro XADAC_HAZARD_SB_STATS_EN adds stall_cnt_o (hazard-stall cycle counter).
module xadac_hazard_sb #(
    parameter int NumIds  = 4,
    parameter int NumRegs = 32,
    parameter int NumSrc  = 3,
    parameter int WrCntW  = 2,
    parameter int IdW     = $clog2(NumIds),
    parameter int RegW    = $clog2(NumRegs)
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    xadac_hazard_sb_if.slave bus,
    output logic busy_o
`ifdef XADAC_HAZARD_SB_STATS_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);
    localparam logic [WrCntW-1:0] CntMax = '1;

    // Retirement clears the whole entry, so the ersp done flag never needs storage.
    logic [RegW-1:0]   vd_q    [NumIds];
    logic [NumSrc-1:0] vs_rd_q [NumIds];
    logic [NumIds-1:0] vd_wr_q, dreq_q, drsp_q, ereq_q;
    logic [WrCntW-1:0] cnt_q   [NumRegs];

    logic              gate;
    logic              dec_req_fire, dec_rsp_fire, exe_req_fire, exe_rsp_fire;
    logic              m_dec_req_valid, s_dec_rsp_valid, m_exe_req_valid, s_exe_rsp_valid;
    logic [IdW-1:0]    qid, rid, eid, xid;
    logic [RegW-1:0]   src_reg [NumSrc];
    logic [NumSrc-1:0] raw_vec;
    logic              sat_haz, hazard;
    logic [NumRegs-1:0] cnt_nz;

    assign gate = !rst && !flush_i;
    assign qid  = bus.s_dec_req_id;
    assign rid  = bus.m_dec_rsp_id;
    assign eid  = bus.s_exe_req_id;
    assign xid  = bus.m_exe_rsp_id;

    assign m_dec_req_valid = gate && bus.s_dec_req_valid && !dreq_q[qid];
    assign dec_req_fire    = m_dec_req_valid && bus.m_dec_req_ready;
    assign s_dec_rsp_valid = gate && bus.m_dec_rsp_valid && dreq_q[rid] && !drsp_q[rid];
    assign dec_rsp_fire    = s_dec_rsp_valid && bus.s_dec_rsp_ready;

    for (genvar gi = 0; gi < NumSrc; gi++) begin : g_src
        assign src_reg[gi] = bus.s_exe_req_vs[gi*RegW +: RegW];
        assign raw_vec[gi] = vs_rd_q[eid][gi] && (cnt_q[src_reg[gi]] != '0);
    end

    // A writer may join others on the same register only while its counter has headroom.
    assign sat_haz         = vd_wr_q[eid] && (cnt_q[vd_q[eid]] == CntMax);
    assign hazard          = (|raw_vec) || sat_haz;
    assign m_exe_req_valid = gate && bus.s_exe_req_valid && drsp_q[eid] && !ereq_q[eid] && !hazard;
    assign exe_req_fire    = m_exe_req_valid && bus.m_exe_req_ready;
    assign s_exe_rsp_valid = gate && bus.m_exe_rsp_valid && ereq_q[xid];
    assign exe_rsp_fire    = s_exe_rsp_valid && bus.s_exe_rsp_ready;

    assign bus.m_dec_req_valid = m_dec_req_valid;
    assign bus.s_dec_req_ready = dec_req_fire;
    assign bus.s_dec_rsp_valid = s_dec_rsp_valid;
    assign bus.m_dec_rsp_ready = dec_rsp_fire;
    assign bus.m_exe_req_valid = m_exe_req_valid;
    assign bus.s_exe_req_ready = exe_req_fire;
    assign bus.s_exe_rsp_valid = s_exe_rsp_valid;
    assign bus.m_exe_rsp_ready = exe_rsp_fire;

    for (genvar gi = 0; gi < NumIds; gi++) begin : g_entry
        logic [RegW-1:0]   vd_d;
        logic [NumSrc-1:0] vs_rd_d;
        logic              vd_wr_d, dreq_d, drsp_d, ereq_d;

        always_comb begin
            vd_d    = vd_q[gi];
            vs_rd_d = vs_rd_q[gi];
            vd_wr_d = vd_wr_q[gi];
            dreq_d  = dreq_q[gi];
            drsp_d  = drsp_q[gi];
            ereq_d  = ereq_q[gi];
            if (dec_req_fire && qid == IdW'(gi)) begin
                vd_d   = bus.s_dec_req_vd;
                dreq_d = 1'b1;
            end
            if (dec_rsp_fire && rid == IdW'(gi)) begin
                if (bus.m_dec_rsp_accept) begin
                    vd_wr_d = bus.m_dec_rsp_vd_wr;
                    vs_rd_d = bus.m_dec_rsp_vs_rd;
                    drsp_d  = 1'b1;
                end else begin
                    vd_d    = '0;
                    vs_rd_d = '0;
                    vd_wr_d = 1'b0;
                    dreq_d  = 1'b0;
                end
            end
            if (exe_req_fire && eid == IdW'(gi)) ereq_d = 1'b1;
            if (exe_rsp_fire && xid == IdW'(gi)) begin
                vd_d    = '0;
                vs_rd_d = '0;
                vd_wr_d = 1'b0;
                dreq_d  = 1'b0;
                drsp_d  = 1'b0;
                ereq_d  = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst || flush_i) begin
                vd_q[gi]    <= '0;
                vs_rd_q[gi] <= '0;
                vd_wr_q[gi] <= 1'b0;
                dreq_q[gi]  <= 1'b0;
                drsp_q[gi]  <= 1'b0;
                ereq_q[gi]  <= 1'b0;
            end else begin
                vd_q[gi]    <= vd_d;
                vs_rd_q[gi] <= vs_rd_d;
                vd_wr_q[gi] <= vd_wr_d;
                dreq_q[gi]  <= dreq_d;
                drsp_q[gi]  <= drsp_d;
                ereq_q[gi]  <= ereq_d;
            end
        end
    end

    for (genvar gi = 0; gi < NumRegs; gi++) begin : g_cnt
        logic              inc, dec;
        logic [WrCntW-1:0] cnt_d;

        assign inc = exe_req_fire && vd_wr_q[eid] && (vd_q[eid] == RegW'(gi));
        assign dec = exe_rsp_fire && vd_wr_q[xid] && (vd_q[xid] == RegW'(gi));

        // Issue and retire on the same register in one cycle cancel out.
        always_comb begin
            cnt_d = cnt_q[gi];
            if (inc && !dec)      cnt_d = cnt_q[gi] + WrCntW'(1);
            else if (dec && !inc) cnt_d = cnt_q[gi] - WrCntW'(1);
        end

        always_ff @(posedge clk) begin
            if (rst || flush_i) cnt_q[gi] <= '0;
            else                cnt_q[gi] <= cnt_d;
        end

        assign cnt_nz[gi] = (cnt_q[gi] != '0);
    end

    assign busy_o = (|dreq_q) || (|cnt_nz);

`ifdef XADAC_HAZARD_SB_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall;

    assign stall = bus.s_exe_req_valid && drsp_q[eid] && !ereq_q[eid] && hazard;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) stall_cnt_q <= '0;
        else                stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_xadac_hazard_sb.sv
// Scoreboard bench for xadac_hazard_sb: expectations are queued as stimulus is driven and
// compared against the sampled handshake outputs at the following falling edge.
module tb_xadac_hazard_sb;
    localparam int IdW    = 2;
    localparam int RegW   = 5;
    localparam int NumSrc = 3;

    localparam int S_MDQV = 0, S_SDQR = 1, S_SDRV = 2, S_MDRR = 3;
    localparam int S_MEQV = 4, S_SEQR = 5, S_SERV = 6, S_MERR = 7, S_BUSY = 8;

    logic clk = 1'b0;
    logic rst;
    logic flush_i;
    logic busy_o;
`ifdef XADAC_HAZARD_SB_STATS_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    xadac_hazard_sb_if #(.IdW(IdW), .RegW(RegW), .NumSrc(NumSrc)) bus_if ();

    xadac_hazard_sb #(.NumIds(4), .NumRegs(32), .NumSrc(NumSrc), .WrCntW(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .bus     (bus_if),
        .busy_o  (busy_o)
`ifdef XADAC_HAZARD_SB_STATS_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        string tag;
        int    sel;
        logic  exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_bit(input int sel);
        case (sel)
            S_MDQV:  return bus_if.m_dec_req_valid;
            S_SDQR:  return bus_if.s_dec_req_ready;
            S_SDRV:  return bus_if.s_dec_rsp_valid;
            S_MDRR:  return bus_if.m_dec_rsp_ready;
            S_MEQV:  return bus_if.m_exe_req_valid;
            S_SEQR:  return bus_if.s_exe_req_ready;
            S_SERV:  return bus_if.s_exe_rsp_valid;
            S_MERR:  return bus_if.m_exe_rsp_ready;
            S_BUSY:  return busy_o;
            default: return 1'bx;
        endcase
    endfunction

    task automatic expect_o(input string tag, input int sel, input logic e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic idle_inputs();
        flush_i                 = 1'b0;
        bus_if.s_dec_req_valid  = 1'b0;
        bus_if.s_dec_req_id     = '0;
        bus_if.s_dec_req_vd     = '0;
        bus_if.m_dec_req_ready  = 1'b1;
        bus_if.m_dec_rsp_valid  = 1'b0;
        bus_if.m_dec_rsp_id     = '0;
        bus_if.m_dec_rsp_accept = 1'b0;
        bus_if.m_dec_rsp_vd_wr  = 1'b0;
        bus_if.m_dec_rsp_vs_rd  = '0;
        bus_if.s_dec_rsp_ready  = 1'b1;
        bus_if.s_exe_req_valid  = 1'b0;
        bus_if.s_exe_req_id     = '0;
        bus_if.s_exe_req_vs     = '0;
        bus_if.m_exe_req_ready  = 1'b1;
        bus_if.m_exe_rsp_valid  = 1'b0;
        bus_if.m_exe_rsp_id     = '0;
        bus_if.s_exe_rsp_ready  = 1'b1;
    endtask

    // Sample at the falling edge, drain the scoreboard, then move to just after the next rising edge.
    task automatic tick(input string what);
        exp_t x;
        int   n;
        @(negedge clk);
        n = sb_q.size();
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check_val(x.tag, {31'b0, obs_bit(x.sel)}, {31'b0, x.exp});
        end
        $display("[%0t] %s: %0d checks", $time, what, n);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic drv_dreq(input int id, input int vd);
        bus_if.s_dec_req_valid = 1'b1;
        bus_if.s_dec_req_id    = IdW'(id);
        bus_if.s_dec_req_vd    = RegW'(vd);
    endtask

    task automatic drv_drsp(input int id, input logic acc, input logic wr, input logic [2:0] rd);
        bus_if.m_dec_rsp_valid  = 1'b1;
        bus_if.m_dec_rsp_id     = IdW'(id);
        bus_if.m_dec_rsp_accept = acc;
        bus_if.m_dec_rsp_vd_wr  = wr;
        bus_if.m_dec_rsp_vs_rd  = rd;
    endtask

    task automatic drv_ereq(input int id, input int v0, input int v1, input int v2);
        bus_if.s_exe_req_valid = 1'b1;
        bus_if.s_exe_req_id    = IdW'(id);
        bus_if.s_exe_req_vs    = {RegW'(v2), RegW'(v1), RegW'(v0)};
    endtask

    task automatic drv_ersp(input int id);
        bus_if.m_exe_rsp_valid = 1'b1;
        bus_if.m_exe_rsp_id    = IdW'(id);
    endtask

    task automatic alloc(input int id, input int vd, input logic wr, input logic [2:0] rd);
        string t;
        t = $sformatf("alloc%0d", id);
        drv_dreq(id, vd);
        expect_o({t, "_mdqv"}, S_MDQV, 1'b1);
        expect_o({t, "_sdqr"}, S_SDQR, 1'b1);
        tick({t, " dec req"});
        drv_drsp(id, 1'b1, wr, rd);
        expect_o({t, "_sdrv"}, S_SDRV, 1'b1);
        expect_o({t, "_mdrr"}, S_MDRR, 1'b1);
        tick({t, " dec rsp"});
    endtask

    task automatic issue(input int id, input int v0, input int v1, input int v2,
                         input logic e, input string tag);
        drv_ereq(id, v0, v1, v2);
        expect_o({tag, "_meqv"}, S_MEQV, e);
        expect_o({tag, "_seqr"}, S_SEQR, e);
        tick(tag);
    endtask

    task automatic retire(input int id);
        string t;
        t = $sformatf("retire%0d", id);
        drv_ersp(id);
        expect_o({t, "_serv"}, S_SERV, 1'b1);
        expect_o({t, "_merr"}, S_MERR, 1'b1);
        tick(t);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset: valids suppressed, nothing tracked.
        drv_dreq(0, 5);
        expect_o("rst_mdqv", S_MDQV, 1'b0);
        expect_o("rst_sdqr", S_SDQR, 1'b0);
        expect_o("rst_busy", S_BUSY, 1'b0);
        tick("reset");
        rst = 1'b0;
        expect_o("post_rst_busy", S_BUSY, 1'b0);
        tick("post reset");

        // Full flow, id 0 writes v5.
        alloc(0, 5, 1'b1, 3'b000);
        expect_o("flow_busy_pre", S_BUSY, 1'b1);
        issue(0, 0, 0, 0, 1'b1, "flow_issue");
        drv_ereq(0, 0, 0, 0);
        drv_ersp(1);
        expect_o("flow_reissue_blk", S_MEQV, 1'b0);
        expect_o("flow_bad_rsp_v", S_SERV, 1'b0);
        expect_o("flow_bad_rsp_r", S_MERR, 1'b0);
        expect_o("flow_busy_mid", S_BUSY, 1'b1);
        tick("flow pending");
        retire(0);
        drv_dreq(0, 5);
        bus_if.m_dec_req_ready = 1'b0;
        drv_drsp(0, 1'b1, 1'b1, 3'b000);
        expect_o("flow_busy_end", S_BUSY, 1'b0);
        expect_o("flow_free_mdqv", S_MDQV, 1'b1);
        expect_o("flow_free_sdqr", S_SDQR, 1'b0);
        expect_o("flow_no_drsp", S_SDRV, 1'b0);
        tick("flow free");

        // RAW on v5 via sources 0 and 1; source 2 reading another register is unaffected.
        alloc(0, 5, 1'b1, 3'b000);
        issue(0, 0, 0, 0, 1'b1, "raw_w_issue");
        alloc(1, 9, 1'b0, 3'b001);
        alloc(2, 10, 1'b0, 3'b100);
        alloc(3, 11, 1'b0, 3'b010);
        issue(1, 5, 0, 0, 1'b0, "raw_src0_blk");
        issue(3, 0, 5, 0, 1'b0, "raw_src1_blk");
        issue(2, 5, 5, 12, 1'b1, "raw_masked_ok");
        retire(2);
        drv_ereq(1, 5, 0, 0);
        drv_ersp(0);
        expect_o("raw_same_cyc_blk", S_MEQV, 1'b0);
        expect_o("raw_w_rsp", S_SERV, 1'b1);
        tick("raw writer retires");
        issue(1, 5, 0, 0, 1'b1, "raw_src0_ok");
        issue(3, 0, 5, 0, 1'b1, "raw_src1_ok");
        retire(1);
        retire(3);
        expect_o("raw_busy_end", S_BUSY, 1'b0);
        tick("raw done");

        // WAW saturation on v3.
        for (int i = 0; i < 4; i++) alloc(i, 3, 1'b1, 3'b000);
        for (int i = 0; i < 3; i++) issue(i, 0, 0, 0, 1'b1, $sformatf("waw_issue%0d", i));
        issue(3, 0, 0, 0, 1'b0, "waw_sat_blk");
        issue(3, 0, 0, 0, 1'b0, "waw_sat_blk2");
        drv_ereq(3, 0, 0, 0);
        drv_ersp(0);
        expect_o("waw_same_cyc_blk", S_MEQV, 1'b0);
        expect_o("waw_rsp0", S_SERV, 1'b1);
        tick("waw one retires");
        issue(3, 0, 0, 0, 1'b1, "waw_issue3");
        for (int i = 1; i < 4; i++) retire(i);
        expect_o("waw_busy_end", S_BUSY, 1'b0);
        tick("waw done");

        // Reject at dec rsp frees the id.
        drv_dreq(2, 8);
        expect_o("rej_mdqv", S_MDQV, 1'b1);
        tick("rej dec req");
        drv_drsp(2, 1'b0, 1'b1, 3'b111);
        expect_o("rej_sdrv", S_SDRV, 1'b1);
        expect_o("rej_mdrr", S_MDRR, 1'b1);
        tick("rej dec rsp");
        drv_dreq(2, 8);
        bus_if.m_dec_req_ready = 1'b0;
        drv_ereq(2, 0, 0, 0);
        expect_o("rej_refwd", S_MDQV, 1'b1);
        expect_o("rej_no_exe", S_MEQV, 1'b0);
        expect_o("rej_busy", S_BUSY, 1'b0);
        tick("rej re-forward");

        // Flush with three entries live and cnt[7]=2.
        alloc(0, 7, 1'b1, 3'b000);
        alloc(1, 7, 1'b1, 3'b000);
        issue(0, 0, 0, 0, 1'b1, "fl_issue0");
        issue(1, 0, 0, 0, 1'b1, "fl_issue1");
        drv_dreq(2, 1);
        expect_o("fl_dreq2", S_MDQV, 1'b1);
        tick("fl third entry");
        flush_i = 1'b1;
        drv_ersp(0);
        drv_dreq(3, 2);
        drv_drsp(2, 1'b1, 1'b0, 3'b000);
        expect_o("fl_mdqv", S_MDQV, 1'b0);
        expect_o("fl_sdqr", S_SDQR, 1'b0);
        expect_o("fl_sdrv", S_SDRV, 1'b0);
        expect_o("fl_serv", S_SERV, 1'b0);
        expect_o("fl_merr", S_MERR, 1'b0);
        expect_o("fl_busy_during", S_BUSY, 1'b1);
        tick("flush");
        expect_o("fl_busy_after", S_BUSY, 1'b0);
        tick("post flush");
        alloc(3, 2, 1'b0, 3'b001);
        issue(3, 7, 0, 0, 1'b1, "fl_read_v7");
        retire(3);

        // Issue and retire on v4 in the same cycle keep cnt[4] at 1.
        alloc(0, 4, 1'b1, 3'b000);
        issue(0, 0, 0, 0, 1'b1, "sim_issue0");
        alloc(1, 4, 1'b1, 3'b000);
        alloc(2, 20, 1'b0, 3'b001);
        drv_ereq(1, 0, 0, 0);
        drv_ersp(0);
        expect_o("sim_meqv1", S_MEQV, 1'b1);
        expect_o("sim_serv0", S_SERV, 1'b1);
        tick("sim issue+retire");
        drv_ereq(2, 4, 0, 0);
        expect_o("sim_cnt_held", S_MEQV, 1'b0);
        expect_o("sim_busy", S_BUSY, 1'b1);
        tick("sim reader held");
        retire(1);
        issue(2, 4, 0, 0, 1'b1, "sim_reader_ok");
        retire(2);
        expect_o("sim_busy_end", S_BUSY, 1'b0);
        tick("sim done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
